// File: rtl/ram4_scan_if.sv
// ram4_scan_if: bus bundle between a ram4_scan bank and its user.
//   master modport : the user. It drives the write data, load, address,
//                    scan_en, scan_ready and (optionally) clear. It reads
//                    d0..d3, sel and the scan status.
//   slave modport  : the ram4_scan bank. The directions are the reverse of
//                    the master modport.
// Optional macro RAM4_SCAN_CLEAR_EN adds the 'clear' signal.
//
// Handshake: a scan beat is transferred on every rising clock edge where
// scan_valid && scan_ready. While scan_ready is low, the slave holds
// scan_valid and sel stable.
interface ram4_scan_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in;
  logic             load;
  logic [1:0]       address;
  logic             scan_en;
  logic             scan_ready;
`ifdef RAM4_SCAN_CLEAR_EN
  logic             clear;
`endif
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [1:0]       sel;
  logic             scan_valid;
  logic             scan_last;
  logic             scan_done;

  modport master (
    output in, load, address, scan_en, scan_ready,
`ifdef RAM4_SCAN_CLEAR_EN
    output clear,
`endif
    input  d0, d1, d2, d3, sel, scan_valid, scan_last, scan_done
  );

  modport slave (
    input  in, load, address, scan_en, scan_ready,
`ifdef RAM4_SCAN_CLEAR_EN
    input  clear,
`endif
    output d0, d1, d2, d3, sel, scan_valid, scan_last, scan_done
  );
endinterface

// File: rtl/ram4_scan.sv
// ram4_scan: a 4-word register bank that feeds a 4-way mux. It drives the
// mux data inputs d0..d3 and the mux select 'sel'.
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : ram4_scan_if.slave. It carries these signals:
//                in, load, address  the write port, captured at the clock rise
//                scan_en, scan_ready  scan request and downstream accept
//                d0..d3               the stored words, with no pipeline stage
//                sel                  the registered mux select
//                scan_valid, scan_last, scan_done  the scan status
//   state_o  : the FSM state, for debug (0=IDLE, 1=SCAN, 2=DONE)
// Parameters:
//   WIDTH     : word width
//   SCAN_WRAP : 1 = the scan restarts at word 0 after word 3 while scan_en
//               stays high
// Optional macro RAM4_SCAN_CLEAR_EN: bus.clear zeroes all words. Clear has
// priority over load.
module ram4_scan #(
  parameter int WIDTH     = 16,
  parameter bit SCAN_WRAP = 1'b0
) (
  input  logic           clock,
  input  logic           reset_n,
  ram4_scan_if.slave     bus,
  output logic [1:0]     state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             scan_en_q;
  logic [WIDTH-1:0] word_q [4];
  logic [WIDTH-1:0] word_d [4];

  // Storage next state.
  always_comb begin
    for (int i = 0; i < 4; i++) word_d[i] = word_q[i];
`ifdef RAM4_SCAN_CLEAR_EN
    if (bus.clear) begin
      for (int i = 0; i < 4; i++) word_d[i] = '0;
    end else if (bus.load) begin
      word_d[bus.address] = bus.in;
    end
`else
    if (bus.load) begin
      word_d[bus.address] = bus.in;
    end
`endif
  end

  // FSM next state and registered outputs.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        sel_d   = bus.address;
        valid_d = 1'b0;
        // Start only on a rising scan_en. This stops a scan_en that stays
        // high after DONE from starting a new scan.
        if (bus.scan_en && !scan_en_q) begin
          state_d = SCAN;
          sel_d   = 2'd0;
          valid_d = 1'b1;
        end
      end
      SCAN: begin
        if (!bus.scan_en) begin
          // An abort has priority over a beat accepted on the same edge.
          state_d = IDLE;
          valid_d = 1'b0;
          sel_d   = bus.address;
        end else if (valid_q && bus.scan_ready) begin
          if (sel_q != 2'd3) begin
            sel_d = sel_q + 2'd1;
          end else if (SCAN_WRAP) begin
            sel_d = 2'd0;
          end else begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sel_q     <= 2'd0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      scan_en_q <= 1'b0;
      for (int i = 0; i < 4; i++) word_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      scan_en_q <= bus.scan_en;
      for (int i = 0; i < 4; i++) word_q[i] <= word_d[i];
    end
  end

  assign bus.d0         = word_q[0];
  assign bus.d1         = word_q[1];
  assign bus.d2         = word_q[2];
  assign bus.d3         = word_q[3];
  assign bus.sel        = sel_q;
  assign bus.scan_valid = valid_q;
  assign bus.scan_last  = valid_q && (sel_q == 2'd3);
  assign bus.scan_done  = done_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_ram4_scan.sv
// Directed testbench for ram4_scan. Inputs change 1 ns after a rising edge,
// and outputs are checked before the next edge.
module tb_ram4_scan;
  localparam int WIDTH = 16;

  logic       clock;
  logic       reset_n;
  logic [1:0] state_o;
  int         n_checks;
  int         n_errors;

  ram4_scan_if #(.WIDTH(WIDTH)) bus ();

  ram4_scan #(.WIDTH(WIDTH), .SCAN_WRAP(1'b0)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .state_o (state_o)
  );

  // Clock and reset.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_words(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3);
    check_eq({tag, "_d0"}, 32'(bus.d0), 32'(e0));
    check_eq({tag, "_d1"}, 32'(bus.d1), 32'(e1));
    check_eq({tag, "_d2"}, 32'(bus.d2), 32'(e2));
    check_eq({tag, "_d3"}, 32'(bus.d3), 32'(e3));
  endtask

  task automatic check_scan(input string tag, input logic [1:0] e_sel, input logic e_valid,
                            input logic e_last, input logic e_done);
    check_eq({tag, "_sel"},   32'(bus.sel),        32'(e_sel));
    check_eq({tag, "_valid"}, 32'(bus.scan_valid), 32'(e_valid));
    check_eq({tag, "_last"},  32'(bus.scan_last),  32'(e_last));
    check_eq({tag, "_done"},  32'(bus.scan_done),  32'(e_done));
  endtask

  // Driver: one load on the next edge.
  task automatic write_word(input logic [1:0] a, input logic [15:0] v);
    bus.load    = 1'b1;
    bus.address = a;
    bus.in      = v;
    tick();
    bus.load    = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset_n        = 1'b0;
    bus.in         = '0;
    bus.load       = 1'b0;
    bus.address    = 2'd0;
    bus.scan_en    = 1'b0;
    bus.scan_ready = 1'b0;
`ifdef RAM4_SCAN_CLEAR_EN
    bus.clear      = 1'b0;
`endif

    // 1. Reset, then writes.
    #12;
    check_words("rst", 16'h0, 16'h0, 16'h0, 16'h0);
    check_scan("rst", 2'd0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_state", 32'(state_o), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check_words("pre_wr", 16'h0, 16'h0, 16'h0, 16'h0);
    write_word(2'd0, 16'h1234);
    check_eq("wr0", 32'(bus.d0), 32'h1234);
    write_word(2'd1, 16'h9876);
    check_eq("wr1", 32'(bus.d1), 32'h9876);
    write_word(2'd2, 16'hAAAA);
    check_eq("wr2", 32'(bus.d2), 32'hAAAA);
    write_word(2'd3, 16'h5555);
    check_words("wr_all", 16'h1234, 16'h9876, 16'hAAAA, 16'h5555);

    // 2. Idle select follows address one cycle later.
    bus.address = 2'd2;
    tick();
    check_eq("idle_sel2", 32'(bus.sel), 32'd2);
    for (int a = 0; a < 4; a++) begin
      logic [1:0] prev;
      prev = bus.sel;
      bus.address = 2'(a);
      #2;
      check_eq("idle_hold", 32'(bus.sel), 32'(prev));
      tick();
      check_eq("idle_follow", 32'(bus.sel), 32'(a));
    end
    // The address is now 3.

    // 3. Full scan with ready held high.
    bus.scan_ready = 1'b1;
    bus.scan_en    = 1'b1;
    tick();
    check_scan("fs0", 2'd0, 1'b1, 1'b0, 1'b0);
    check_eq("fs0_state", 32'(state_o), 32'd1);
    tick(); check_scan("fs1", 2'd1, 1'b1, 1'b0, 1'b0);
    tick(); check_scan("fs2", 2'd2, 1'b1, 1'b0, 1'b0);
    tick(); check_scan("fs3", 2'd3, 1'b1, 1'b1, 1'b0);
    tick(); check_scan("fs_done", 2'd3, 1'b0, 1'b0, 1'b1);
    check_eq("fs_done_state", 32'(state_o), 32'd2);
    tick(); check_scan("fs_idle", 2'd3, 1'b0, 1'b0, 1'b0);
    check_eq("fs_idle_state", 32'(state_o), 32'd0);
    tick(); check_scan("fs_norestart", 2'd3, 1'b0, 1'b0, 1'b0);
    bus.scan_en = 1'b0;
    tick();

    // 4. Backpressure at sel=1.
    bus.scan_en = 1'b1;
    tick(); check_scan("bp0", 2'd0, 1'b1, 1'b0, 1'b0);
    tick(); check_scan("bp1", 2'd1, 1'b1, 1'b0, 1'b0);
    bus.scan_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_scan("bp_hold", 2'd1, 1'b1, 1'b0, 1'b0);
    end
    bus.scan_ready = 1'b1;
    tick(); check_scan("bp_go", 2'd2, 1'b1, 1'b0, 1'b0);

    // 5a. Abort at sel=2. The address is 3.
    bus.scan_en = 1'b0;
    tick();
    check_scan("abort", 2'd3, 1'b0, 1'b0, 1'b0);
    check_eq("abort_state", 32'(state_o), 32'd0);
    tick(); check_eq("abort_nodone", 32'(bus.scan_done), 32'd0);

    // 5b. Asynchronous reset at sel=1.
    bus.scan_en = 1'b1;
    tick();
    tick(); check_scan("rs1", 2'd1, 1'b1, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check_scan("arst", 2'd0, 1'b0, 1'b0, 1'b0);
    check_words("arst", 16'h0, 16'h0, 16'h0, 16'h0);
    tick();
    reset_n     = 1'b1;
    bus.scan_en = 1'b0;
    tick();

    // 6. Write during a stalled scan at sel=3.
    bus.scan_en = 1'b1;
    tick(); tick(); tick(); tick();
    check_scan("ws3", 2'd3, 1'b1, 1'b1, 1'b0);
    bus.scan_ready = 1'b0;
    write_word(2'd3, 16'hFFFF);
    check_eq("ws_d3", 32'(bus.d3), 32'hFFFF);
    check_scan("ws_hold", 2'd3, 1'b1, 1'b1, 1'b0);
`ifdef RAM4_SCAN_CLEAR_EN
    bus.clear   = 1'b1;
    bus.load    = 1'b1;
    bus.address = 2'd0;
    bus.in      = 16'h1111;
    tick();
    bus.clear   = 1'b0;
    bus.load    = 1'b0;
    check_words("clr", 16'h0, 16'h0, 16'h0, 16'h0);
    check_scan("clr_hold", 2'd3, 1'b1, 1'b1, 1'b0);
`endif
    bus.scan_ready = 1'b1;
    tick(); check_scan("ws_done", 2'd3, 1'b0, 1'b0, 1'b1);
    bus.scan_en = 1'b0;
    tick(); check_eq("ws_idle_state", 32'(state_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ram4_scan.md
Name: ram4_scan

Overview:
- 4-word x 16-bit register bank that sits directly upstream of the team's 4-way 16-bit mux.
- Drives the mux's four data inputs (d3..d0) and its 2-bit select.
- Select is either address-following (idle) or an auto-incrementing scan with a valid/ready handshake.
- A scan lets a downstream consumer walk all four words in order, one per accepted beat.

Parameters:
- WIDTH, 16, word width of every storage entry and data port.
- SCAN_WRAP, 0, 1 = scan restarts at word 0 after word 3 while scan_en stays high; 0 = single pass.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in  input  WIDTH  write data.
- load  input  1  write strobe; captured on clock rise.
- address  input  2  write address; idle-mode select source.
- scan_en  input  1  request/continue scan.
- scan_ready  input  1  downstream accepts the current word.
- d0  output  WIDTH  word 0 (mux input d0).
- d1  output  WIDTH  word 1.
- d2  output  WIDTH  word 2.
- d3  output  WIDTH  word 3.
- sel  output  2  registered mux select.
- scan_valid  output  1  sel is presenting a scan beat.
- scan_last  output  1  scan_valid and sel==3.
- scan_done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (reset_n low, asynchronous):
  - all four words = 0, sel = 0, scan_valid = 0, scan_done = 0, state = IDLE.
  - Takes effect immediately, including mid-scan.
  - The first clock rise after reset_n goes high is a normal cycle.
- Storage:
  - load=1 at clock rise writes in into word[address]; the new value is on d[address] after that edge (1-cycle write latency).
  - d0..d3 are driven directly from storage, with no extra pipeline stage.
  - Writes are legal in every state. Writing the currently selected word during SCAN does not stall or drop scan_valid; the downstream sees the new value from the next cycle.
- State machine: IDLE, SCAN, DONE.
  - IDLE:
    - sel <= address every cycle (1-cycle latency); scan_valid = 0.
    - scan_en=1 -> SCAN, with sel <= 0 and scan_valid <= 1 on the same edge.
  - SCAN:
    - scan_valid = 1. A beat is accepted when scan_valid && scan_ready at a clock rise.
    - Accepted beat with sel<3: sel <= sel+1.
    - Accepted beat with sel==3 and SCAN_WRAP=0: -> DONE, scan_valid <= 0, scan_done <= 1.
    - Accepted beat with sel==3, SCAN_WRAP=1 and scan_en=1: sel <= 0 (2-bit wrap), stay in SCAN, no scan_done.
    - scan_ready=0 holds sel and scan_valid unchanged indefinitely.
    - scan_en=0 at any clock rise (abort) -> IDLE, scan_valid <= 0, no scan_done, sel <= address. Abort wins over a simultaneous accepted beat.
  - DONE:
    - scan_done = 1 for exactly this cycle, then -> IDLE.
    - scan_en still high in DONE does not restart. scan_en must be seen low in IDLE before a new scan starts (edge-qualified via a registered scan_en).
- scan_last is combinational: scan_valid && (sel==3).
- address is ignored for sel while in SCAN and DONE.

Optional Feature:
- Macro RAM4_SCAN_CLEAR_EN.
- Defined:
  - Adds input port clear (1 bit).
  - clear=1 at clock rise zeroes all four words.
  - clear has priority over load in the same cycle; the load is dropped.
  - The scan state is unaffected.
- Undefined: no clear port; storage changes only via load or reset.

Test Plan:
1. Reset and write: hold reset_n=0, then release. Write word0=0x1234, word1=0x9876, word2=0xAAAA, word3=0x5555 on four cycles -> d0..d3 show those values one cycle after each write. Before the writes, all d and sel are 0.
2. Idle select: address=2 with load=0 -> sel==2 after one clock. Cycling address 0..3 shows sel trailing by one cycle.
3. Full scan with ready always 1 and SCAN_WRAP=0:
   - Raise scan_en -> sel goes 0,1,2,3 on consecutive cycles with scan_valid=1.
   - scan_last=1 only at sel=3.
   - scan_done pulses one cycle, then IDLE.
   - Holding scan_en high does not restart the scan.
4. Backpressure: during a scan, scan_ready=0 for 3 cycles at sel=1 -> sel stays 1 and scan_valid stays 1. Then ready=1 -> sel advances to 2.
5. Abort and reset mid-scan:
   - Drop scan_en at sel=2 with ready=1 -> IDLE next cycle, scan_valid=0, no scan_done.
   - Separately, assert reset_n=0 at sel=1 -> sel=0, scan_valid=0 and all words=0 immediately, without waiting for a clock.
6. Write during scan: at sel=3 with ready=0, load word3=0xFFFF -> d3=0xFFFF next cycle and scan_valid stays 1. With RAM4_SCAN_CLEAR_EN defined, clear and load together -> all words=0.
